// File: rtl/tube_scan_ctrl.sv
// tube_scan_ctrl: multiplexed 7-segment scan with dwell, blanking, LZ suppression, frame-coherent capture
// Optional blink support is compiled in when TUBE_BLINK_EN is defined.
module tube_scan_ctrl #(
   parameter int DIGITS    = 8,
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 2,
   parameter int BLINK_DIV = 50,
   localparam int SW = $clog2(DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   digit_bcd,
   input  logic [DIGITS-1:0]     sep_mask,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic [DIGITS-1:0]     blink_mask,
   input  logic                  lz_en,
   output logic [SW-1:0]         sel,
   output logic [7:0]            seg,
   output logic                  frame_start
);
   localparam int PW = $clog2(SCAN_DIV + 1);
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [7:0] seg_q, seg_d;
   logic frame_start_q, frame_start_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic [DIGITS-1:0] sep_q, sep_d, dp_q, dp_d, lz_blank;
   logic lz_q, lz_d, valid_q, valid_d;
   logic slot_end, wrap, run, blink_off, lz_off;
   logic [3:0] cur_bcd;
`ifdef TUBE_BLINK_EN
   localparam int FW = $clog2(BLINK_DIV + 1);
   logic [DIGITS-1:0] blink_q, blink_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic phase_q, phase_d;
`else
   logic unused_blink;
   assign unused_blink = ^blink_mask;
`endif

   function automatic logic [6:0] dec(input logic [3:0] b);
      case (b)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h79;
      endcase
   endfunction

   // Next-state: scan position, shadow capture on wrap, and the segment pattern for the upcoming slot
   always_comb begin
      slot_end = pcnt_q == PW'(SCAN_DIV - 1);
      wrap = slot_end && sel_q == SW'(DIGITS - 1);
      pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;
      sel_d = wrap ? '0 : sel_q + SW'(slot_end);
      frame_start_d = wrap;
      bcd_d = wrap ? digit_bcd : bcd_q;
      sep_d = wrap ? sep_mask : sep_q;
      dp_d = wrap ? dp_mask : dp_q;
      lz_d = wrap ? lz_en : lz_q;
      valid_d = valid_q | wrap;
      run = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         run = run & ~sep_d[i] & (bcd_d[4*i +: 4] == 4'd0);
         lz_blank[i] = run;
      end
`ifdef TUBE_BLINK_EN
      blink_d = wrap ? blink_mask : blink_q;
      fcnt_d = wrap ? (fcnt_q == FW'(BLINK_DIV - 1) ? '0 : fcnt_q + 1'b1) : fcnt_q;
      phase_d = phase_q ^ (wrap && fcnt_q == FW'(BLINK_DIV - 1));
      blink_off = phase_d & blink_d[sel_d];
`else
      blink_off = 1'b0;
`endif
      lz_off = lz_d && lz_blank[sel_d] && sel_d != SW'(DIGITS - 1);
      cur_bcd = bcd_d[4*sel_d +: 4];
      seg_d = (!valid_d || pcnt_d < PW'(BLANK_CYC) || blink_off || lz_off) ? 8'h00 :
              {dp_d[sel_d], sep_d[sel_d] ? 7'h40 : dec(cur_bcd)};
   end

   // State registers; async reset blanks the tube immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q <= '0;
         sel_q <= '0;
         seg_q <= '0;
         frame_start_q <= 1'b0;
         bcd_q <= '0;
         sep_q <= '0;
         dp_q <= '0;
         lz_q <= 1'b0;
         valid_q <= 1'b0;
`ifdef TUBE_BLINK_EN
         blink_q <= '0;
         fcnt_q <= '0;
         phase_q <= 1'b0;
`endif
      end else begin
         pcnt_q <= pcnt_d;
         sel_q <= sel_d;
         seg_q <= seg_d;
         frame_start_q <= frame_start_d;
         bcd_q <= bcd_d;
         sep_q <= sep_d;
         dp_q <= dp_d;
         lz_q <= lz_d;
         valid_q <= valid_d;
`ifdef TUBE_BLINK_EN
         blink_q <= blink_d;
         fcnt_q <= fcnt_d;
         phase_q <= phase_d;
`endif
      end
   end

   assign sel = sel_q;
   assign seg = seg_q;
   assign frame_start = frame_start_q;
endmodule

// File: tb/tb_tube_scan_ctrl.sv
// tb_tube_scan_ctrl: directed table-driven bench for tube_scan_ctrl (DIGITS=8, SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=2)
module tb_tube_scan_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] digit_bcd = '0;
   logic [7:0] sep_mask = '0, dp_mask = '0, blink_mask = '0;
   logic lz_en = 1'b0;
   logic [2:0] sel;
   logic [7:0] seg;
   logic frame_start;
   int n_chk = 0, n_fail = 0;

`ifdef TUBE_BLINK_EN
   localparam bit BL = 1'b1;
`else
   localparam bit BL = 1'b0;
`endif

   typedef logic [0:7][7:0] frame_t;
   typedef struct packed {
      logic [31:0] bcd;
      logic [7:0]  sep;
      logic [7:0]  dp;
      logic        lz;
      frame_t      seg;
   } vec_t;
   vec_t tv [7];

   tube_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(2)) dut (
      .clk(clk), .rst(rst), .digit_bcd(digit_bcd), .sep_mask(sep_mask), .dp_mask(dp_mask),
      .blink_mask(blink_mask), .lz_en(lz_en), .sel(sel), .seg(seg), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply(input vec_t v);
      digit_bcd = v.bcd;
      sep_mask = v.sep;
      dp_mask = v.dp;
      lz_en = v.lz;
   endtask

   task automatic wait_fs();
      int n = 0;
      do begin
         tick();
         n++;
      end while (!frame_start && n < 40);
      chk("frame_start_timeout", frame_start, 1'b1);
   endtask

   // Entered at the frame_start cycle (sel 0, pcnt 0); leaves on the last cycle of the frame
   task automatic check_frame(input string nm, input frame_t e);
      for (int d = 0; d < 8; d++) begin
         if (d > 0) tick();
         chk($sformatf("%s_blank%0d", nm, d), seg, 8'h00);
         tick();
         chk($sformatf("%s_sel%0d", nm, d), sel, d);
         chk($sformatf("%s_seg%0d", nm, d), seg, e[d]);
         tick();
         tick();
      end
   endtask

   initial begin
      frame_t eb;
      // digit i sits at nibble i, so hex literals read right-to-left across the tube
      tv[0] = '{32'h87654321, 8'h00, 8'h00, 1'b0, {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F}};
      tv[1] = '{32'h65043921, 8'b00100100, 8'b00000010, 1'b0, {8'h06, 8'hDB, 8'h40, 8'h4F, 8'h66, 8'h40, 8'h6D, 8'h7D}};
      tv[2] = '{32'h50100000, 8'h00, 8'h01, 1'b1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h3F, 8'h6D}};
      tv[3] = '{32'h00000000, 8'h00, 8'h00, 1'b1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F}};
      tv[4] = '{32'h00000000, 8'h00, 8'h00, 1'b0, {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F}};
      tv[5] = '{32'h00000000, 8'h04, 8'h00, 1'b1, {8'h00, 8'h00, 8'h40, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F}};
      tv[6] = '{32'hFEDCBA98, 8'h00, 8'h00, 1'b0, {8'h7F, 8'h6F, 8'h79, 8'h79, 8'h79, 8'h79, 8'h79, 8'h79}};
      apply(tv[0]);
      tick();
      chk("rst_sel", sel, 0);
      chk("rst_seg", seg, 8'h00);
      chk("rst_fs", frame_start, 1'b0);
      rst = 1'b0;
      for (int n = 1; n <= 32; n++) begin
         tick();
         chk($sformatf("scan_sel_c%0d", n), sel, (n / 4) % 8);
         chk($sformatf("scan_fs_c%0d", n), frame_start, n == 32);
         if (n < 32) chk($sformatf("scan_seg_c%0d", n), seg, 8'h00);
      end
      for (int v = 0; v < 7; v++) begin
         check_frame($sformatf("vec%0d", v), tv[v].seg);
         apply(v < 6 ? tv[v + 1] : tv[0]);
         wait_fs();
      end
      // change inputs while sel==3: rest of frame must keep old values
      for (int k = 0; k < 13; k++) tick();
      chk("tear_sel3", sel, 3);
      apply(tv[4]);
      for (int d = 3; d < 8; d++) begin
         if (d > 3) for (int k = 0; k < 4; k++) tick();
         chk($sformatf("tear_old%0d", d), seg, tv[0].seg[d]);
      end
      wait_fs();
      check_frame("tear_new", tv[4].seg);
      wait_fs();
      // async reset mid-frame at sel 5, pcnt 2
      for (int k = 0; k < 22; k++) tick();
      chk("arst_pre_sel", sel, 5);
      chk("arst_pre_seg", seg, 8'h3F);
      rst = 1'b1;
      #1;
      chk("arst_sel", sel, 0);
      chk("arst_seg", seg, 8'h00);
      chk("arst_fs", frame_start, 1'b0);
      apply(tv[0]);
      blink_mask = 8'h03;
      tick();
      rst = 1'b0;
      wait_fs();
      check_frame("blink_f1", tv[0].seg);
      eb = tv[0].seg;
      if (BL) begin
         eb[0] = 8'h00;
         eb[1] = 8'h00;
      end
      wait_fs();
      check_frame("blink_f2", eb);
      wait_fs();
      check_frame("blink_f3", eb);
      wait_fs();
      check_frame("blink_f4", tv[0].seg);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
